row_pair_packer: RTL

ROW_PAIR_PACKER -- requirements
Module: row_pair_packer

---
 rtl/row_pair_packer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/row_pair_packer.sv
// Packs a raster stream of unsigned pixels into {odd, even} signed coefficient pairs
// for a row DWT, with symmetric extension on odd-length rows and sticky error flags.
module row_pair_packer #(
  parameter int DataWidth       = 16,
  parameter int PixelWidth      = 8,
  parameter int InShift         = 6,
  parameter int LevelShift      = 1,
  parameter int MaximumSideSize = 512
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  output logic                   s_ready_o,
  input  logic                   s_valid_i,
  input  logic                   s_sof_i,
  input  logic                   s_eol_i,
  input  logic [PixelWidth-1:0]  s_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o,
  output logic [1:0]             err_o
);

  if (PixelWidth + InShift + 1 > DataWidth) begin : gen_width_check
    $error("row_pair_packer: DataWidth too small for PixelWidth + InShift + sign");
  end

  localparam int CntW = $clog2(MaximumSideSize + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaximumSideSize);
  localparam logic [DataWidth-1:0] LevelOffset =
    (LevelShift != 0) ? (DataWidth'(1) << (PixelWidth - 1)) : '0;

  typedef enum logic {StEven, StOdd} state_e;

  state_e                 state_q;
  logic [CntW-1:0]        rowCnt_q, rowCnt_d;
  logic [DataWidth-1:0]   heldEven_q, lastOdd_q;
  logic                   heldSof_q;
  logic                   mValid_q, mSof_q, mEol_q;
  logic [2*DataWidth-1:0] mData_q;
  logic [1:0]             err_q;

  logic [DataWidth-1:0]   pixExt, sampleVal;
  logic                   accept;

  // Two's complement subtraction then shift gives the level-shifted fixed-point sample.
  assign pixExt    = DataWidth'(s_data_i);
  assign sampleVal = (pixExt - LevelOffset) << InShift;

  assign s_ready_o = ~mValid_q | m_ready_i;
  assign accept    = s_valid_i & s_ready_o;

  assign m_valid_o = mValid_q;
  assign m_sof_o   = mSof_q;
  assign m_eol_o   = mEol_q;
  assign m_data_o  = mData_q;
  assign err_o     = err_q;

  // Counter saturates so an oversized row keeps flagging without wrapping to index 0.
  always_comb begin
    rowCnt_d = rowCnt_q;
    if (accept) begin
      if (s_eol_i) begin
        rowCnt_d = '0;
      end else if (rowCnt_q != CntMax) begin
        rowCnt_d = rowCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StEven;
      rowCnt_q   <= '0;
      heldEven_q <= '0;
      heldSof_q  <= 1'b0;
      lastOdd_q  <= '0;
      mValid_q   <= 1'b0;
      mSof_q     <= 1'b0;
      mEol_q     <= 1'b0;
      mData_q    <= '0;
      err_q      <= 2'b00;
    end else begin
      rowCnt_q <= rowCnt_d;
      if (mValid_q && m_ready_i) begin
        mValid_q <= 1'b0;
      end
      if (accept) begin
        if (rowCnt_q == CntMax) begin
          err_q[1] <= 1'b1;
        end
        case (state_q)
          StEven: begin
            if (!s_eol_i) begin
              heldEven_q <= sampleVal;
              heldSof_q  <= s_sof_i;
              state_q    <= StOdd;
            end else if (rowCnt_q == '0) begin
              mValid_q <= 1'b1;
              mData_q  <= {sampleVal, sampleVal};
              mSof_q   <= s_sof_i;
              mEol_q   <= 1'b1;
            end else begin
              // Whole-sample symmetric extension: missing x[N] mirrors x[N-2].
              mValid_q <= 1'b1;
              mData_q  <= {lastOdd_q, sampleVal};
              mSof_q   <= 1'b0;
              mEol_q   <= 1'b1;
            end
          end
          StOdd: begin
            mValid_q  <= 1'b1;
            mData_q   <= {sampleVal, heldEven_q};
            mSof_q    <= heldSof_q;
            mEol_q    <= s_eol_i;
            lastOdd_q <= sampleVal;
            state_q   <= StEven;
            if (s_sof_i) begin
              err_q[0] <= 1'b1;
            end
          end
          default: state_q <= StEven;
        endcase
      end
    end
  end

endmodule
